// File: rtl/scie_fir_mc.sv
// Multi-channel FIR custom-instruction unit: per-channel coefficient and sample
// storage sharing one multiplier that sweeps one tap per cycle.
module scie_fir_mc #(
  parameter int DATA_W    = 16,
  parameter int TAPS      = 8,
  parameter int CHANNELS  = 4,
  parameter int FRAC_BITS = 16,
  parameter int XLEN      = 32
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            io_valid,
  input  logic [31:0]     io_insn,
  input  logic [XLEN-1:0] io_rs1,
  input  logic [XLEN-1:0] io_rs2,
  output logic [XLEN-1:0] io_rd,
  output logic            io_ready,
  output logic [15:0]     io_drops
);

  localparam int TAP_W = $clog2(TAPS);
  localparam int CH_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int ACC_W = 2 * DATA_W + TAP_W;

  localparam logic [6:0] OP_LOAD  = 7'h0B;
  localparam logic [6:0] OP_PUSH  = 7'h2B;
  localparam logic [6:0] OP_READ  = 7'h5B;
  localparam logic [6:0] OP_CLEAR = 7'h7B;

  typedef enum logic [1:0] {IDLE, MAC, DONE} state_t;

  state_t            state;
  logic [DATA_W-1:0] coef   [CHANNELS][TAPS];
  logic [DATA_W-1:0] hist   [CHANNELS][TAPS];
  logic [XLEN-1:0]   result [CHANNELS];
  logic [CH_W-1:0]   sweep_ch;
  logic [TAP_W-1:0]  k;
  logic [ACC_W-1:0]  acc;

  function automatic logic [XLEN-1:0] scale_result(input logic [ACC_W-1:0] a);
    logic [ACC_W-1:0] s;
    s = a >> FRAC_BITS;
    return XLEN'(s);
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] c);
    return (c == 16'hFFFF) ? c : c + 16'd1;
  endfunction

  // CHANNELS is a power of two, so the modulo reduces to a mask.
  function automatic logic [CH_W-1:0] chan_of(input logic [7:0] f);
    logic [7:0] m;
    m = f & 8'(CHANNELS - 1);
    return CH_W'(m);
  endfunction

  logic [6:0]        op;
  logic [CH_W-1:0]   ch;
  logic [7:0]        idx;
  logic              idx_ok;
  logic [TAP_W-1:0]  tap;
  logic              is_load, is_push, is_read, is_clear;
  logic [2*DATA_W-1:0] prod;
  logic              unused_bits;

  assign op       = io_insn[6:0];
  assign ch       = chan_of(io_rs2[15:8]);
  assign idx      = io_rs2[7:0];
  assign idx_ok   = ({24'd0, idx} < 32'(TAPS));
  assign tap      = idx[TAP_W-1:0];
  assign is_load  = io_valid && (op == OP_LOAD);
  assign is_push  = io_valid && (op == OP_PUSH);
  assign is_read  = io_valid && (op == OP_READ);
  assign is_clear = io_valid && (op == OP_CLEAR);
  assign prod     = (2*DATA_W)'(hist[sweep_ch][k]) * (2*DATA_W)'(coef[sweep_ch][k]);
  assign unused_bits = ^{io_insn[31:7], io_rs1[XLEN-1:DATA_W], io_rs2[XLEN-1:16]};

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      io_ready <= 1'b1;
      io_drops <= 16'd0;
      io_rd    <= '0;
      acc      <= '0;
      k        <= '0;
      sweep_ch <= '0;
      for (int c = 0; c < CHANNELS; c++) begin
        result[c] <= '0;
        for (int t = 0; t < TAPS; t++) begin
          coef[c][t] <= '0;
          hist[c][t] <= '0;
        end
      end
    end else begin
      case (state)
        IDLE: begin
          if (is_push) begin
            for (int t = TAPS - 1; t > 0; t--) hist[ch][t] <= hist[ch][t-1];
            hist[ch][0] <= io_rs1[DATA_W-1:0];
            sweep_ch    <= ch;
            k           <= '0;
            acc         <= '0;
            io_ready    <= 1'b0;
            state       <= MAC;
          end
        end
        MAC: begin
          acc <= acc + ACC_W'(prod);
          k   <= k + 1'b1;
          if (k == TAP_W'(TAPS - 1)) state <= DONE;
        end
        DONE: begin
          result[sweep_ch] <= scale_result(acc);
          io_ready         <= 1'b1;
          state            <= IDLE;
        end
        default: begin
          io_ready <= 1'b1;
          state    <= IDLE;
        end
      endcase

      if (is_push && state != IDLE) io_drops <= sat_inc(io_drops);
      if (is_load && idx_ok) coef[ch][tap] <= io_rs1[DATA_W-1:0];
      if (is_read) io_rd <= result[ch];

      // Clearing the channel under sweep aborts it; placed last so it wins over DONE.
      if (is_clear) begin
        for (int t = 0; t < TAPS; t++) hist[ch][t] <= '0;
        result[ch] <= '0;
        if (state != IDLE && sweep_ch == ch) begin
          state    <= IDLE;
          io_ready <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_scie_fir_mc.sv
// Directed and randomized bench for scie_fir_mc against a behavioural FIR model.
module tb_scie_fir_mc;
  localparam int DATA_W = 16, TAPS = 8, CHANNELS = 4, FRAC_BITS = 16, XLEN = 32;
  localparam logic [6:0] OP_LOAD = 7'h0B, OP_PUSH = 7'h2B, OP_READ = 7'h5B, OP_CLEAR = 7'h7B;

  logic            clock = 1'b0;
  logic            reset;
  logic            io_valid;
  logic [31:0]     io_insn;
  logic [XLEN-1:0] io_rs1, io_rs2, io_rd;
  logic            io_ready;
  logic [15:0]     io_drops;

  scie_fir_mc #(.DATA_W(DATA_W), .TAPS(TAPS), .CHANNELS(CHANNELS),
                .FRAC_BITS(FRAC_BITS), .XLEN(XLEN)) dut (
    .clock(clock), .reset(reset), .io_valid(io_valid), .io_insn(io_insn),
    .io_rs1(io_rs1), .io_rs2(io_rs2), .io_rd(io_rd), .io_ready(io_ready),
    .io_drops(io_drops));

  always #5 clock = ~clock;

  int checks = 0, passed = 0, failed = 0;
  longint unsigned coef_m [CHANNELS][TAPS];
  longint unsigned hist_m [CHANNELS][TAPS];
  logic [31:0]     res_m  [CHANNELS];

  int unsigned c0   [5] = '{52345, 51674, 64687, 11306, 42746};
  int unsigned s0   [5] = '{28315, 33076, 27880, 63880, 38666};
  int unsigned exp0 [5] = '{22615, 48744, 76296, 110537, 132945};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < CHANNELS; c++) begin
      res_m[c] = 0;
      for (int t = 0; t < TAPS; t++) begin coef_m[c][t] = 0; hist_m[c][t] = 0; end
    end
  endtask

  task automatic model_push(input int c, input longint unsigned s);
    longint unsigned sum;
    for (int t = TAPS - 1; t > 0; t--) hist_m[c][t] = hist_m[c][t-1];
    hist_m[c][0] = s;
    sum = 0;
    for (int t = 0; t < TAPS; t++) sum += hist_m[c][t] * coef_m[c][t];
    res_m[c] = 32'(sum >> FRAC_BITS);
  endtask

  task automatic issue(input logic [6:0] op, input logic [31:0] rs1, input int c, input int idx);
    @(negedge clock);
    io_valid = 1'b1;
    io_insn  = {25'd0, op};
    io_rs1   = rs1;
    io_rs2   = {16'd0, 8'(c), 8'(idx)};
    @(negedge clock);
    io_valid = 1'b0;
    io_insn  = '0;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!io_ready && n < 64) begin @(negedge clock); n++; end
    if (!io_ready) check("wait_ready_timeout", 32'(io_ready), 32'd1);
  endtask

  task automatic load(input int c, input int t, input int unsigned v);
    issue(OP_LOAD, v, c, t);
    if (t < TAPS) coef_m[c][t] = longint'(v & 32'hFFFF);
  endtask

  task automatic push(input int c, input int unsigned s);
    wait_ready();
    issue(OP_PUSH, s, c, 0);
    model_push(c, longint'(s & 32'hFFFF));
  endtask

  task automatic read_check(input int c, input string tag);
    wait_ready();
    issue(OP_READ, 0, c, 0);
    check(tag, io_rd, res_m[c]);
  endtask

  task automatic clear(input int c);
    issue(OP_CLEAR, 0, c, 0);
    res_m[c] = 0;
    for (int t = 0; t < TAPS; t++) hist_m[c][t] = 0;
  endtask

  initial begin
    logic [31:0] prev;
    reset = 1'b1; io_valid = 1'b0; io_insn = '0; io_rs1 = '0; io_rs2 = '0;
    model_reset();
    repeat (2) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    check("reset_rd", io_rd, 32'd0);
    check("reset_ready", 32'(io_ready), 32'd1);
    check("reset_drops", 32'(io_drops), 32'd0);

    // Test-plan vector on ch0
    for (int i = 0; i < 5; i++) load(0, i, c0[i]);
    for (int i = 0; i < 5; i++) begin
      push(0, s0[i]);
      read_check(0, $sformatf("ch0_model_%0d", i));
      check($sformatf("ch0_vector_%0d", i), io_rd, exp0[i]);
    end

    // Same samples on unloaded ch2
    for (int i = 0; i < 5; i++) begin
      push(2, s0[i]);
      read_check(2, $sformatf("ch2_zero_%0d", i));
    end
    read_check(0, "ch0_unaffected");
    check("ch0_unaffected_const", io_rd, 32'd132945);

    // Clear ch0 mid-sweep
    push(0, 12345);
    repeat (3) @(negedge clock);
    check("busy_mid_sweep", 32'(io_ready), 32'd0);
    clear(0);
    check("clear_ready", 32'(io_ready), 32'd1);
    read_check(0, "clear_read");
    push(0, 28315);
    read_check(0, "after_clear_push");
    check("after_clear_const", io_rd, 32'd22615);

    // Out-of-range LOAD and unknown opcode leave state alone
    load(0, 9, 40000);
    issue(7'h7F, 32'hFFFF, 0, 1);
    issue(OP_READ, 0, 0, 0);
    check("ignored_ops_read", io_rd, 32'd22615);
    push(0, 33076);
    read_check(0, "ignored_ops_push");
    check("ignored_ops_const", io_rd, 32'd48744);

    // Randomized coefficients and samples on ch1 and ch3
    for (int c = 1; c < CHANNELS; c += 2) begin
      for (int t = 0; t < TAPS; t++) load(c, t, $urandom_range(0, 65535));
      for (int i = 0; i < 10; i++) begin
        prev = res_m[c];
        push(c, $urandom_range(0, 65535));
        if (i % 2 == 0) begin
          issue(OP_READ, 0, c, 0);
          check($sformatf("busy_read_ch%0d_%0d", c, i), io_rd, prev);
        end
        read_check(c, $sformatf("rand_ch%0d_%0d", c, i));
      end
    end

    // Back-to-back push: second one dropped
    push(1, $urandom_range(0, 65535));
    issue(OP_PUSH, $urandom_range(0, 65535), 1, 0);
    check("drop_count_1", 32'(io_drops), 32'd1);
    read_check(1, "drop_history_once");

    // Continuous push flood to saturate the drop counter
    wait_ready();
    @(negedge clock);
    io_valid = 1'b1; io_insn = {25'd0, OP_PUSH}; io_rs1 = 32'd777; io_rs2 = {16'd0, 8'd1, 8'd0};
    repeat (74000) @(negedge clock);
    io_valid = 1'b0; io_insn = '0;
    check("drops_saturated", 32'(io_drops), 32'd65535);
    wait_ready();
    clear(1);
    read_check(1, "ch1_cleared");

    // Reset mid-sweep
    push(0, 50000);
    repeat (3) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    model_reset();
    check("midreset_rd", io_rd, 32'd0);
    check("midreset_ready", 32'(io_ready), 32'd1);
    check("midreset_drops", 32'(io_drops), 32'd0);
    push(0, 28315);
    read_check(0, "midreset_push_zero");
    push(3, 65535);
    read_check(3, "midreset_ch3_zero");

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
